lvds_frame_capture: RTL and testbench

Parametrised LVDS capture framer in the CLK_IN (source-synchronous) domain. It samples CH lanes of DW-bit post-IBUFDS data plus the D_GROUP marker, aligns frames to the rising edge of D_GROUP, and emits fixed-length frames with start- and end-of-frame flags into the write side of the async packet FIFO. A frame is started only when the FIFO reports room for the whole frame, so partial frames never reach the AXI-Stream/DMA side.

---
 rtl/lvds_pkg.sv | 27 ++
 rtl/lvds_sync_2ff.sv | 24 ++
 rtl/lvds_frame_capture.sv | 169 ++++++++++++++++
 tb/tb_lvds_frame_capture.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
// Shared types and default sizes for the LVDS capture framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lvds_pkg;

    // Default sizing of the capture path.
    localparam int LVDS_CH_DEF        = 1;
    localparam int LVDS_DW_DEF        = 15;
    localparam int LVDS_FRAME_LEN_DEF = 512;
    localparam int LVDS_FIFO_AW_DEF   = 12;

    // Width of the frame sequence and drop counters.
    localparam int LVDS_CNT_W = 16;

    // Framer states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        CAPTURE   = 2'd2
    } lvds_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [LVDS_CNT_W-1:0] sat_inc(input logic [LVDS_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lvds_sync_2ff.sv
// Two-flop synchroniser that brings a slow level into the CLK_IN domain.
// Latency: 2 CLK_IN edges from a stable input to q.
// Backpressure: none; samples every cycle.
module lvds_sync_2ff (
    input  logic CLK_IN,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous level through two flops; both clear on reset.
    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lvds_frame_capture.sv
// Aligns LVDS lane samples to the D_GROUP rising edge and writes fixed-length frames into a FIFO.
// Latency: pin to wr_data 2 cycles (3 with LVDS_FRAME_HEADER_EN, which also prepends a frame_seq header word).
// Backpressure: a frame starts only if fifo_wr_space covers it; otherwise it is dropped and counted.
module lvds_frame_capture
    import lvds_pkg::*;
#(
    parameter  int CH        = LVDS_CH_DEF,
    parameter  int DW        = LVDS_DW_DEF,
    parameter  int FRAME_LEN = LVDS_FRAME_LEN_DEF,
    parameter  int FIFO_AW   = LVDS_FIFO_AW_DEF,
    localparam int WORD_W    = CH * DW + 1
) (
    input  logic                  CLK_IN,
    input  logic                  rst_n,
    input  logic [CH*DW-1:0]      DATA_IN,
    input  logic                  D_GROUP,
    input  logic                  arm,
    input  logic [FIFO_AW:0]      fifo_wr_space,
    input  logic                  fifo_full,
    output logic                  wr_en,
    output logic [WORD_W-1:0]     wr_data,
    output logic                  wr_sof,
    output logic                  wr_eof,
    output logic [LVDS_CNT_W-1:0] frame_seq,
    output logic [LVDS_CNT_W-1:0] drop_cnt,
    output logic                  overflow,
    output logic                  busy
);

`ifdef LVDS_FRAME_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    // Entries a frame needs in the FIFO, and the index of its last data word.
    localparam logic [31:0]           NEED_SPACE = 32'(FRAME_LEN + HDR);
    localparam logic [LVDS_CNT_W-1:0] LAST_WORD  = LVDS_CNT_W'(FRAME_LEN - 1);

    // Word 0 is written on the sync cycle without a header, so the counter
    // then starts at 1; with a header, word 0 comes one cycle later.
    localparam logic [LVDS_CNT_W-1:0] FIRST_CNT  = LVDS_CNT_W'(1 - HDR);

    logic [CH*DW-1:0]      data_r;
    logic                  group_r;
    logic                  group_d;
    logic                  sync;
    logic                  arm_s;
    logic                  space_ok;
    logic [WORD_W-1:0]     cap_word;
    logic [WORD_W-1:0]     data_word;
    logic [WORD_W-1:0]     hdr_word;
    lvds_state_t           state;
    logic [LVDS_CNT_W-1:0] word_cnt;

    // Input register stage: one flop on every pin, plus a second on the group
    // marker so its rising edge can be detected.
    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= '0;
            group_r <= 1'b0;
            group_d <= 1'b0;
        end else begin
            data_r  <= DATA_IN;
            group_r <= D_GROUP;
            group_d <= group_r;
        end
    end

    assign sync     = group_r & ~group_d;
    assign cap_word = {group_r, data_r};
    assign space_ok = 32'(fifo_wr_space) >= NEED_SPACE;
    assign hdr_word = WORD_W'(frame_seq);

    lvds_sync_2ff u_arm_sync (
        .CLK_IN (CLK_IN),
        .rst_n  (rst_n),
        .d      (arm),
        .q      (arm_s)
    );

`ifdef LVDS_FRAME_HEADER_EN
    logic [WORD_W-1:0] cap_word_d;

    // Extra data stage so the header word can occupy the sync cycle while
    // data word 0 follows one cycle behind it.
    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            cap_word_d <= '0;
        end else begin
            cap_word_d <= cap_word;
        end
    end

    assign data_word = cap_word_d;
`else
    assign data_word = cap_word;
`endif

    // Framer FSM: waits for an armed sync with enough space, then streams
    // FRAME_LEN words; all FIFO-side outputs are registered here.
    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_cnt  <= '0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            wr_sof    <= 1'b0;
            wr_eof    <= 1'b0;
            frame_seq <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_en  <= 1'b0;
            wr_sof <= 1'b0;
            wr_eof <= 1'b0;

            // A strobe presented while the FIFO is full loses that word.
            if (wr_en && fifo_full) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (arm_s) begin
                        state <= WAIT_SYNC;
                    end
                end

                WAIT_SYNC: begin
                    if (!arm_s) begin
                        state <= IDLE;
                    end else if (sync) begin
                        if (space_ok) begin
                            state    <= CAPTURE;
                            busy     <= 1'b1;
                            wr_en    <= 1'b1;
                            wr_sof   <= 1'b1;
                            wr_data  <= (HDR != 0) ? hdr_word : data_word;
                            word_cnt <= FIRST_CNT;
                        end else begin
                            drop_cnt <= sat_inc(drop_cnt);
                        end
                    end
                end

                CAPTURE: begin
                    // Syncs and arm changes are ignored until the frame ends.
                    wr_en    <= 1'b1;
                    wr_data  <= data_word;
                    word_cnt <= word_cnt + 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        wr_eof    <= 1'b1;
                        frame_seq <= frame_seq + 1'b1;
                        busy      <= 1'b0;
                        state     <= arm_s ? WAIT_SYNC : IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_frame_capture.sv
// Bench for lvds_frame_capture: directed scenarios plus random sync/space traffic against a frame-level model.
// Latency: model expects pin cycle s on wr_data two edges later (one more with LVDS_FRAME_HEADER_EN).
// Backpressure: fifo_wr_space and fifo_full are driven by the bench.
module tb_lvds_frame_capture;

    localparam int FL   = 8;
    localparam int DWT  = 15;
    localparam int AW   = 12;
    localparam int WW   = DWT + 1;
    localparam int MAXE = 2048;
`ifdef LVDS_FRAME_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam logic [AW:0] SP_BIG   = 13'd100;
    localparam logic [AW:0] SP_EXACT = 13'(FL + HDR);
    localparam logic [AW:0] SP_SHORT = 13'(FL + HDR - 1);

    logic            CLK_IN = 1'b0;
    logic            rst_n;
    logic [DWT-1:0]  DATA_IN;
    logic            D_GROUP;
    logic            arm;
    logic [AW:0]     fifo_wr_space;
    logic            fifo_full;
    logic            wr_en;
    logic [WW-1:0]   wr_data;
    logic            wr_sof;
    logic            wr_eof;
    logic [15:0]     frame_seq;
    logic [15:0]     drop_cnt;
    logic            overflow;
    logic            busy;

    lvds_frame_capture #(
        .CH(1), .DW(DWT), .FRAME_LEN(FL), .FIFO_AW(AW)
    ) dut (
        .CLK_IN        (CLK_IN),
        .rst_n         (rst_n),
        .DATA_IN       (DATA_IN),
        .D_GROUP       (D_GROUP),
        .arm           (arm),
        .fifo_wr_space (fifo_wr_space),
        .fifo_full     (fifo_full),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_sof        (wr_sof),
        .wr_eof        (wr_eof),
        .frame_seq     (frame_seq),
        .drop_cnt      (drop_cnt),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 CLK_IN = ~CLK_IN;

    // Expected events per clock edge n, filled in when a sync is judged.
    logic           ev_en     [MAXE];
    logic           ev_sof    [MAXE];
    logic           ev_eof    [MAXE];
    logic           ev_hdr    [MAXE];
    logic [15:0]    ev_hdrv   [MAXE];
    int             ev_src    [MAXE];
    logic           ev_seqinc [MAXE];
    logic           ev_drop   [MAXE];
    logic           ev_ovf    [MAXE];
    // Pin history per drive cycle.
    logic           hist_g    [MAXE];
    logic [DWT-1:0] hist_d    [MAXE];

    int          n       = 0;
    int          next_ok = 0;
    bit          m_arm   = 1'b0;
    logic [15:0] m_seq   = '0;
    logic [15:0] m_drop  = '0;
    logic        m_ovf   = 1'b0;
    logic        a_v     = 1'b0;
    logic        r_v     = 1'b0;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_from(input int from);
        for (int i = from; i < MAXE; i++) begin
            ev_en[i] = 1'b0; ev_sof[i] = 1'b0; ev_eof[i] = 1'b0; ev_hdr[i] = 1'b0;
            ev_hdrv[i] = '0; ev_src[i] = 0; ev_seqinc[i] = 1'b0; ev_drop[i] = 1'b0;
            ev_ovf[i] = 1'b0;
        end
    endtask

    // Compare DUT outputs after edge n against the model.
    task automatic check_edge();
        logic [WW-1:0] exp_w;
        m_seq = m_seq + 16'(ev_seqinc[n]);
        if (ev_drop[n] && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        if (ev_ovf[n]) m_ovf = 1'b1;
        chk("wr_en", 32'(wr_en), 32'(ev_en[n]));
        if (ev_en[n]) begin
            exp_w = ev_hdr[n] ? ev_hdrv[n] : {hist_g[ev_src[n]], hist_d[ev_src[n]]};
            chk("wr_data", 32'(wr_data), 32'(exp_w));
            chk("wr_sof", 32'(wr_sof), 32'(ev_sof[n]));
            chk("wr_eof", 32'(wr_eof), 32'(ev_eof[n]));
        end
        chk("busy", 32'(busy), 32'(ev_en[n] & ~ev_eof[n]));
        chk("frame_seq", 32'(frame_seq), 32'(m_seq));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Record the pins for cycle n and judge the sync (if any) seen on cycle n-1.
    task automatic model_drive(input logic g, input logic [DWT-1:0] d, input logic [AW:0] sp, input logic f);
        int s;
        int e;
        hist_g[n] = g;
        hist_d[n] = d;
        if (!r_v) begin
            clear_from(n + 1);
            m_seq = '0; m_drop = '0; m_ovf = 1'b0; next_ok = 0; m_arm = 1'b0;
            return;
        end
        if (f && ev_en[n]) ev_ovf[n + 1] = 1'b1;
        if (n >= 2 && m_arm && hist_g[n - 1] && !hist_g[n - 2]) begin
            s = n - 1;
            if (s >= next_ok) begin
                if (int'(sp) >= FL + HDR) begin
                    if (HDR != 0) begin
                        ev_en[s + 2] = 1'b1; ev_hdr[s + 2] = 1'b1;
                        ev_hdrv[s + 2] = m_seq; ev_sof[s + 2] = 1'b1;
                    end
                    for (int i = 0; i < FL; i++) begin
                        e = s + 2 + HDR + i;
                        ev_en[e] = 1'b1;
                        ev_src[e] = s + i;
                        ev_sof[e] = (HDR == 0) && (i == 0);
                        ev_eof[e] = (i == FL - 1);
                        ev_seqinc[e] = (i == FL - 1);
                    end
                    next_ok = s + FL + HDR;
                end else begin
                    ev_drop[s + 2] = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic g, input logic [DWT-1:0] d, input logic [AW:0] sp, input logic f);
        @(negedge CLK_IN);
        n++;
        check_edge();
        D_GROUP = g; DATA_IN = d; fifo_wr_space = sp; fifo_full = f;
        arm = a_v; rst_n = r_v;
        model_drive(g, d, sp, f);
    endtask

    task automatic idle(input int k, input logic [AW:0] sp);
        for (int i = 0; i < k; i++) step(1'b0, DWT'($urandom), sp, 1'b0);
    endtask

    task automatic pulse(input logic [DWT-1:0] d, input logic [AW:0] sp);
        step(1'b1, d, sp, 1'b0);
        step(1'b1, DWT'($urandom), sp, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1);
    end

    initial begin
        int s;
        logic g_r;
        logic [AW:0] sp_r;
        clear_from(0);
        for (int i = 0; i < MAXE; i++) begin hist_g[i] = 1'b0; hist_d[i] = '0; end
        rst_n = 1'b0; arm = 1'b0; D_GROUP = 1'b0; DATA_IN = '0; fifo_wr_space = SP_BIG; fifo_full = 1'b0;

        // Reset values.
        idle(3, SP_BIG);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_wr_sof", 32'(wr_sof), 32'd0);
        chk("rst_wr_eof", 32'(wr_eof), 32'd0);
        r_v = 1'b1; idle(2, SP_BIG);
        a_v = 1'b1; idle(8, SP_BIG); m_arm = 1'b1;

        // Space available: one frame carrying 0x1234 as word 0.
        pulse(15'h1234, SP_BIG); idle(14, SP_BIG);
        chk("t1_frame_seq", 32'(frame_seq), 32'd1);

        // One short of space: dropped; exactly enough: written.
        pulse(DWT'($urandom), SP_SHORT); idle(12, SP_SHORT);
        chk("t2_drop", 32'(drop_cnt), 32'd1);
        chk("t2_seq", 32'(frame_seq), 32'd1);
        pulse(DWT'($urandom), SP_EXACT); idle(14, SP_EXACT);
        chk("t2_seq_after", 32'(frame_seq), 32'd2);

        // Back-to-back frames with a sync injected mid-frame.
        pulse(DWT'($urandom), SP_BIG); idle(1, SP_BIG);
        pulse(DWT'($urandom), SP_BIG); idle(FL + HDR - 5, SP_BIG);
        pulse(DWT'($urandom), SP_BIG); idle(14, SP_BIG);
        chk("t3_seq", 32'(frame_seq), 32'd4);
        chk("t3_drop", 32'(drop_cnt), 32'd1);

        // Random group edges, data and space.
        g_r = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) g_r = ~g_r;
            case ($urandom_range(0, 3))
                0:       sp_r = SP_SHORT;
                1:       sp_r = SP_EXACT;
                2:       sp_r = 13'd200;
                default: sp_r = '0;
            endcase
            step(g_r, DWT'($urandom), sp_r, 1'b0);
        end
        idle(20, SP_BIG);

        // arm dropped at word 3: frame completes, later syncs ignored.
        s = n + 1;
        pulse(DWT'($urandom), SP_BIG);
        while (n < s + 4 + HDR) idle(1, SP_BIG);
        a_v = 1'b0; m_arm = 1'b0;
        idle(15, SP_BIG);
        pulse(DWT'($urandom), SP_BIG); idle(6, SP_BIG);
        pulse(DWT'($urandom), SP_BIG); idle(6, SP_BIG);
        chk("t4_busy", 32'(busy), 32'd0);
        a_v = 1'b1; idle(8, SP_BIG); m_arm = 1'b1;

        // fifo_full during word 5 sets sticky overflow.
        s = n + 1;
        pulse(DWT'($urandom), SP_BIG);
        while (n < s + 6 + HDR) idle(1, SP_BIG);
        step(1'b0, DWT'($urandom), SP_BIG, 1'b1);
        idle(15, SP_BIG);
        chk("t5_overflow", 32'(overflow), 32'd1);
        pulse(DWT'($urandom), SP_BIG); idle(14, SP_BIG);
        chk("t5_overflow_sticky", 32'(overflow), 32'd1);

        // Reset mid-frame abandons the frame and clears every output.
        pulse(DWT'($urandom), SP_BIG); idle(3, SP_BIG);
        r_v = 1'b0; idle(1, SP_BIG); idle(1, SP_BIG);
        chk("t6_wr_en", 32'(wr_en), 32'd0);
        chk("t6_wr_data", 32'(wr_data), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        chk("t6_frame_seq", 32'(frame_seq), 32'd0);
        idle(2, SP_BIG);
        r_v = 1'b1; idle(8, SP_BIG); m_arm = 1'b1;
        pulse(DWT'($urandom), SP_BIG); idle(14, SP_BIG);
        chk("t6_recover_seq", 32'(frame_seq), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
